// File: rtl/comperator_bist_pkg.sv
// Shared types and golden compare model for the comperator BIST and the comparator's own bench.
package comperator_pkg;

  localparam int DEFAULT_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Returns {equal, less, great}; always one-hot for a correct unsigned comparator.
  function automatic logic [2:0] expected_flags(input logic [31:0] a, input logic [31:0] b);
    return {a == b, a < b, a > b};
  endfunction

endpackage

// File: rtl/comperator_bist_if.sv
// Operand/flag link between the BIST initiator (master) and the comparator under test (slave).
interface comperator_bist_if
  import comperator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             equal;
  logic             less;
  logic             great;

  modport master (output A, output B, input equal, input less, input great);
  modport slave  (input A, input B, output equal, output less, output great);

endinterface

// File: rtl/comperator_bist.sv
// Exhaustive {A,B} sweep of an external comparator; each vector is held SETTLE cycles, then
// the flags are checked against the golden model. Reports pass, mismatch count and first failing vector.
module comperator_bist
  import comperator_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  comperator_bist_if.master    cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     fail_count,
  output logic                 first_fail_valid,
  output logic [2*WIDTH-1:0]   first_fail_vec
);

  localparam int VW = 2 * WIDTH;
  localparam int FW = 2 * WIDTH + 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [VW-1:0] VEC_LAST = '1;

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
  logic            ffv_q, ffv_d;
  logic [VW-1:0]   ffvec_q, ffvec_d;

  logic [2:0]      exp_flags;
  logic            mismatch;
  logic [FW-1:0]   fail_cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      ffv_q      <= ffv_d;
      ffvec_q    <= ffvec_d;
    end
  end

  // Any deviation from one-hot expected flags, including zero-hot/multi-hot, is a mismatch.
  always_comb begin
    exp_flags    = expected_flags(32'(vec_q[VW-1:WIDTH]), 32'(vec_q[WIDTH-1:0]));
    mismatch     = ({cmp.equal, cmp.less, cmp.great} != exp_flags);
    fail_cnt_inc = fail_cnt_q + FW'(mismatch);
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d      = '0;
          cnt_d      = SETTLE_C;
          fail_cnt_d = '0;
          ffv_d      = 1'b0;
          ffvec_d    = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        fail_cnt_d = fail_cnt_inc;
        if (mismatch && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec_q;
        end
        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + VW'(1);
          cnt_d   = SETTLE_C;
          state_d = WAIT;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_inc == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmp.A            = vec_q[VW-1:WIDTH];
  assign cmp.B            = vec_q[WIDTH-1:0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_comperator_bist.sv
// Bench for comperator_bist: fault-injecting comparator model, lagging comparators for settle-time checks.
module tb_comperator_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Main DUT, defaults
  comperator_bist_if #(.WIDTH(2)) cmp_if ();
  logic busy, done, pass, ffv;
  logic [4:0] fcnt;
  logic [3:0] ffvec;

  comperator_bist #(.WIDTH(2), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp(cmp_if),
    .busy(busy), .done(done), .pass(pass), .fail_count(fcnt),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  // Fault model: 0 good, 1 great stuck-0, 2 equal stuck-1, 3 per-vector XOR corruption
  int         flt_mode = 0;
  logic [2:0] corrupt [16];

  always_comb begin
    logic [3:0] v;
    logic [2:0] f;
    v = {cmp_if.A, cmp_if.B};
    f = {cmp_if.A == cmp_if.B, cmp_if.A < cmp_if.B, cmp_if.A > cmp_if.B};
    case (flt_mode)
      1: f[0] = 1'b0;
      2: f[2] = 1'b1;
      3: f = f ^ corrupt[v];
      default: ;
    endcase
    {cmp_if.equal, cmp_if.less, cmp_if.great} = f;
  end

  // Two comparators whose flags lag the operands by two cycles
  comperator_bist_if #(.WIDTH(2)) cmp3_if ();
  comperator_bist_if #(.WIDTH(2)) cmp1_if ();
  logic [2:0] lag3_p1, lag3_p2, lag1_p1, lag1_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lag3_p1 <= '0; lag3_p2 <= '0; lag1_p1 <= '0; lag1_p2 <= '0;
    end else begin
      lag3_p1 <= {cmp3_if.A == cmp3_if.B, cmp3_if.A < cmp3_if.B, cmp3_if.A > cmp3_if.B};
      lag3_p2 <= lag3_p1;
      lag1_p1 <= {cmp1_if.A == cmp1_if.B, cmp1_if.A < cmp1_if.B, cmp1_if.A > cmp1_if.B};
      lag1_p2 <= lag1_p1;
    end
  end
  assign {cmp3_if.equal, cmp3_if.less, cmp3_if.great} = lag3_p2;
  assign {cmp1_if.equal, cmp1_if.less, cmp1_if.great} = lag1_p2;

  logic busy3, done3, pass3, ffv3, busy1, done1, pass1, ffv1;
  logic [4:0] fcnt3, fcnt1;
  logic [3:0] ffvec3, ffvec1;

  comperator_bist #(.WIDTH(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cmp(cmp3_if),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fcnt3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
  );

  comperator_bist #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmp(cmp1_if),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fcnt1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start (optionally holding it over the following WAIT and CHECK edges) and counts edges to done.
  task automatic run_sweep(input string tag, input bit poke, output int edges);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = poke;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 2) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(edges), 32'd32);
  endtask

  task automatic check_res(input string tag, input int exp_cnt, input int exp_first);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(exp_cnt == 0));
    check({tag, "_fcnt"}, 32'(fcnt), 32'(exp_cnt));
    check({tag, "_ffv"}, 32'(ffv), 32'(exp_cnt != 0));
    check({tag, "_ffvec"}, 32'(ffvec), (exp_cnt != 0) ? 32'(exp_first) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int exp_cnt;
    int exp_first;
    int seen;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fcnt", 32'(fcnt), 32'd0);
    check("rst_ffv", 32'(ffv), 32'd0);
    check("rst_vec", 32'({cmp_if.A, cmp_if.B}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Good comparator
    flt_mode = 0;
    run_sweep("good", 1'b0, edges);
    check_res("good", 0, 0);

    // great stuck-at-0: six A>B vectors, first {A=1,B=0}
    flt_mode = 1;
    run_sweep("great_sa0", 1'b0, edges);
    check_res("great_sa0", 6, 4);

    // equal stuck-at-1: every A!=B vector fails, first is 0001
    flt_mode = 2;
    run_sweep("equal_sa1", 1'b0, edges);
    check_res("equal_sa1", 12, 1);

    // Start held over WAIT and CHECK edges is ignored
    run_sweep("poke", 1'b1, edges);
    check_res("poke", 12, 1);

    // Start held high in DONE restarts at once; results identical
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("restart_done_low", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_fcnt_clr", 32'(fcnt), 32'd0);
    start = 1'b0;
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("restart_latency", 32'(edges), 32'd32);
    check_res("restart", 12, 1);

    // Random per-vector corruption against a count/first-index reference
    flt_mode = 3;
    for (int r = 0; r < 4; r++) begin
      exp_cnt = 0;
      exp_first = -1;
      for (int v = 0; v < 16; v++) begin
        corrupt[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        if (corrupt[v] != 3'd0) begin
          exp_cnt++;
          if (exp_first < 0) exp_first = v;
        end
      end
      run_sweep("rand", 1'b0, edges);
      check_res("rand", exp_cnt, exp_first);
    end

    // Async reset mid-cycle while vec == 7, with failures accumulated so far
    flt_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      if ({cmp_if.A, cmp_if.B} == 4'd7) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("vec7_reached", 32'(seen), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_fcnt", 32'(fcnt), 32'd0);
    check("arst_ffv", 32'(ffv), 32'd0);
    check("arst_ffvec", 32'(ffvec), 32'd0);
    check("arst_vec", 32'({cmp_if.A, cmp_if.B}), 32'd0);
    rst = 1'b0;
    flt_mode = 0;
    run_sweep("post_rst", 1'b0, edges);
    check_res("post_rst", 0, 0);

    // Two-cycle-lag comparator: SETTLE=3 passes in 64 edges, SETTLE=1 fails
    @(negedge clk);
    start3 = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    start1 = 1'b0;
    edges = 0;
    while (!done3 && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("lag_s3_latency", 32'(edges), 32'd64);
    check("lag_s3_pass", 32'(pass3), 32'd1);
    check("lag_s3_fcnt", 32'(fcnt3), 32'd0);
    check("lag_s1_done", 32'(done1), 32'd1);
    check("lag_s1_pass", 32'(pass1), 32'd0);
    check("lag_s1_fcnt_nz", 32'(fcnt1 != 5'd0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
